ibex_pmu_arbiter: RTL and testbench

Round-robin arbiter that shares the single PMU counter interface between `NumReq` requesters, such as per-hart counter units or a debug/trace agent. It sequences one transaction at a time onto the counter interface and holds the winner's op, address, write enable and write data until the response arrives. It routes the response back to the owner only. A timeout with drain recovery protects against lost responses on register accesses (`PMC_REQ`). It sits between the requesters and the PMU.

---
 rtl/ibex_pmu_arbiter.sv | 227 ++++++++++++++++++++++
 tb/tb_ibex_pmu_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ibex_pmu_arbiter.sv
// ibex_pmu_arbiter: round-robin arbiter that shares one PMU counter interface
// between NumReq requesters. It runs one transaction at a time, holds the
// owner's payload until the response arrives, and returns the response to the
// owner only. A timeout with drain recovery covers lost register-access
// responses.

package ibex_pmu_pkg;

    typedef enum logic [1:0] {
        PMC_IDLE = 2'b00,
        PMC_REQ  = 2'b01,
        PMC_WFP  = 2'b10,
        PMC_WFO  = 2'b11
    } pmc_op_e;

endpackage

module ibex_pmu_arbiter
    import ibex_pmu_pkg::*;
#(
    parameter int unsigned NumReq        = 2,
    parameter int unsigned TimeoutCycles = 64
) (
    input  logic                     clk_i,
    input  logic                     rst_i,

    input  pmc_op_e [NumReq-1:0]     req_op_i,
    input  logic    [NumReq-1:0][31:0] req_addr_i,
    input  logic    [NumReq-1:0]     req_we_i,
    input  logic    [NumReq-1:0][31:0] req_wdata_i,
    output logic    [NumReq-1:0]     req_gnt_o,
    output logic    [NumReq-1:0]     req_rvalid_o,
    output logic                     req_err_o,
    output logic    [31:0]           req_rdata_o,

    output pmc_op_e                  counter_op_o,
    input  logic                     counter_gnt_i,
    input  logic                     counter_rvalid_i,
    input  logic                     counter_err_i,
    output logic    [31:0]           counter_addr_o,
    output logic                     counter_we_o,
    output logic    [31:0]           counter_wdata_o,
    input  logic    [31:0]           counter_rdata_i
);

    // Index width for requester numbers; one extra bit for the wrap-around sum.
    localparam int unsigned IdxW = (NumReq > 32'd1) ? $clog2(NumReq) : 32'd1;
    localparam int unsigned SumW = IdxW + 32'd1;

    // Timeout counter sizing. A zero TimeoutCycles disables the timeout; the
    // counter is then kept one bit wide and never advances.
    localparam int unsigned CntW = (TimeoutCycles > 32'd0) ? $clog2(TimeoutCycles + 32'd1) : 32'd1;
    localparam logic        TmoEn = (TimeoutCycles > 32'd0);
    // The timeout fires in the TimeoutCycles-th REQ cycle, i.e. when the
    // counter (cleared on grant) still shows TimeoutCycles-1.
    localparam logic [CntW-1:0] TmoLast = (TimeoutCycles > 32'd0) ? CntW'(TimeoutCycles - 32'd1) : '0;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NumReq - 32'd1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_WFX   = 2'd2,
        ST_DRAIN = 2'd3
    } state_e;

    state_e          state_q, state_d;
    logic [IdxW-1:0] owner_q, owner_d;
    pmc_op_e         op_q, op_d;
    logic [31:0]     addr_q, addr_d;
    logic            we_q, we_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [IdxW-1:0] rr_ptr_q, rr_ptr_d;
    logic [CntW-1:0] tmo_q, tmo_d;

    logic            win_valid_s;
    logic [IdxW-1:0] win_idx_s;
    logic [SumW-1:0] cand_sum_s;
    logic [IdxW-1:0] cand_s;

    // Round-robin search: first requester with a non-idle op, starting at rr_ptr_q.
    always_comb begin
        win_valid_s = 1'b0;
        win_idx_s   = '0;
        cand_sum_s  = '0;
        cand_s      = '0;
        for (int unsigned k = 32'd0; k < NumReq; k++) begin
            cand_sum_s = {1'b0, rr_ptr_q} + SumW'(k);
            if (cand_sum_s >= SumW'(NumReq)) begin
                cand_sum_s = cand_sum_s - SumW'(NumReq);
            end else begin
                cand_sum_s = cand_sum_s;
            end
            cand_s = cand_sum_s[IdxW-1:0];
            if (!win_valid_s && (req_op_i[cand_s] != PMC_IDLE)) begin
                win_valid_s = 1'b1;
                win_idx_s   = cand_s;
            end else begin
                win_valid_s = win_valid_s;
            end
        end
    end

    // Next-state logic, transaction latching and combinational output steering.
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        op_d     = op_q;
        addr_d   = addr_q;
        we_d     = we_q;
        wdata_d  = wdata_q;
        rr_ptr_d = rr_ptr_q;
        tmo_d    = tmo_q;

        req_gnt_o       = '0;
        req_rvalid_o    = '0;
        req_err_o       = 1'b0;
        req_rdata_o     = 32'h0000_0000;
        counter_op_o    = PMC_IDLE;
        counter_addr_o  = addr_q;
        counter_we_o    = we_q;
        counter_wdata_o = wdata_q;

        case (state_q)
            ST_IDLE: begin
                // Present the current winner straight to the PMU so the grant
                // can be taken in this same cycle.
                if (win_valid_s) begin
                    counter_op_o    = req_op_i[win_idx_s];
                    counter_addr_o  = req_addr_i[win_idx_s];
                    counter_we_o    = req_we_i[win_idx_s];
                    counter_wdata_o = req_wdata_i[win_idx_s];
                    if (counter_gnt_i) begin
                        req_gnt_o[win_idx_s] = 1'b1;
                        owner_d  = win_idx_s;
                        op_d     = req_op_i[win_idx_s];
                        addr_d   = req_addr_i[win_idx_s];
                        we_d     = req_we_i[win_idx_s];
                        wdata_d  = req_wdata_i[win_idx_s];
                        rr_ptr_d = (win_idx_s == LastIdx) ? '0 : (win_idx_s + IdxW'(1));
                        tmo_d    = '0;
                        case (req_op_i[win_idx_s])
                            PMC_REQ:          state_d = ST_REQ;
                            PMC_WFP, PMC_WFO: state_d = ST_WFX;
                            default:          state_d = ST_IDLE;
                        endcase
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    counter_op_o = PMC_IDLE;
                end
            end

            ST_REQ: begin
                // A real response wins over a timeout firing in the same cycle.
                if (counter_rvalid_i) begin
                    req_rvalid_o[owner_q] = 1'b1;
                    req_err_o             = counter_err_i;
                    req_rdata_o           = counter_rdata_i;
                    tmo_d                 = '0;
                    state_d               = ST_IDLE;
                end else if (TmoEn && (tmo_q == TmoLast)) begin
                    req_rvalid_o[owner_q] = 1'b1;
                    req_err_o             = 1'b1;
                    req_rdata_o           = 32'h0000_0000;
                    tmo_d                 = '0;
                    state_d               = ST_DRAIN;
                end else if (TmoEn) begin
                    tmo_d = tmo_q + CntW'(1);
                end else begin
                    tmo_d = tmo_q;
                end
            end

            ST_WFX: begin
                // Wait-for ops keep the op asserted until the PMU answers; the
                // op drops in the response cycle itself.
                if (counter_rvalid_i) begin
                    counter_op_o          = PMC_IDLE;
                    req_rvalid_o[owner_q] = 1'b1;
                    req_err_o             = counter_err_i;
                    req_rdata_o           = counter_rdata_i;
                    state_d               = ST_IDLE;
                end else begin
                    counter_op_o = op_q;
                end
            end

            ST_DRAIN: begin
                // Swallow the late response of a timed-out access.
                if (counter_rvalid_i) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DRAIN;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and transaction registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            owner_q  <= '0;
            op_q     <= PMC_IDLE;
            addr_q   <= 32'h0000_0000;
            we_q     <= 1'b0;
            wdata_q  <= 32'h0000_0000;
            rr_ptr_q <= '0;
            tmo_q    <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            op_q     <= op_d;
            addr_q   <= addr_d;
            we_q     <= we_d;
            wdata_q  <= wdata_d;
            rr_ptr_q <= rr_ptr_d;
            tmo_q    <= tmo_d;
        end
    end

endmodule

// File: tb/tb_ibex_pmu_arbiter.sv
// Scoreboard bench for ibex_pmu_arbiter (NumReq = 3, TimeoutCycles = 4).
// Stimulus pushes expected grants/responses into queues; a negedge monitor
// pops and compares whenever the DUT raises a grant or response strobe.

module tb_ibex_pmu_arbiter;
    import ibex_pmu_pkg::*;

    localparam int unsigned N = 3;

    typedef struct packed {
        logic [N-1:0] vec;
        logic         err;
        logic [31:0]  rdata;
    } rsp_t;

    logic                   clk = 1'b0;
    logic                   rst_i;
    pmc_op_e [N-1:0]        req_op;
    logic    [N-1:0][31:0]  req_addr;
    logic    [N-1:0]        req_we;
    logic    [N-1:0][31:0]  req_wdata;
    logic    [N-1:0]        req_gnt_o;
    logic    [N-1:0]        req_rvalid_o;
    logic                   req_err_o;
    logic    [31:0]         req_rdata_o;
    pmc_op_e                counter_op_o;
    logic                   counter_gnt_i;
    logic                   counter_rvalid_i;
    logic                   counter_err_i;
    logic    [31:0]         counter_addr_o;
    logic                   counter_we_o;
    logic    [31:0]         counter_wdata_o;
    logic    [31:0]         counter_rdata_i;

    logic [N-1:0] gnt_q[$];
    rsp_t         rsp_q[$];
    logic [N-1:0] mon_g;
    rsp_t         mon_r;
    logic [N-1:0] onehot;
    int           total = 0;
    int           bad   = 0;

    ibex_pmu_arbiter #(
        .NumReq        (N),
        .TimeoutCycles (4)
    ) dut (
        .clk_i            (clk),
        .rst_i            (rst_i),
        .req_op_i         (req_op),
        .req_addr_i       (req_addr),
        .req_we_i         (req_we),
        .req_wdata_i      (req_wdata),
        .req_gnt_o        (req_gnt_o),
        .req_rvalid_o     (req_rvalid_o),
        .req_err_o        (req_err_o),
        .req_rdata_o      (req_rdata_o),
        .counter_op_o     (counter_op_o),
        .counter_gnt_i    (counter_gnt_i),
        .counter_rvalid_i (counter_rvalid_i),
        .counter_err_i    (counter_err_i),
        .counter_addr_o   (counter_addr_o),
        .counter_we_o     (counter_we_o),
        .counter_wdata_o  (counter_wdata_o),
        .counter_rdata_i  (counter_rdata_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_gnt(input logic [N-1:0] v);
        gnt_q.push_back(v);
    endtask

    task automatic exp_rsp(input logic [N-1:0] v, input logic e, input logic [31:0] d);
        rsp_t r;
        r.vec   = v;
        r.err   = e;
        r.rdata = d;
        rsp_q.push_back(r);
    endtask

    task automatic idle_ops();
        for (int i = 0; i < N; i++) req_op[i] = PMC_IDLE;
    endtask

    // Monitor: every grant or response strobe must match the next expected entry.
    always @(negedge clk) begin
        if (!rst_i) begin
            if (req_gnt_o != '0) begin
                if (gnt_q.size() == 0) begin
                    chk("gnt_unexpected", 32'(req_gnt_o), 32'd0);
                end else begin
                    mon_g = gnt_q.pop_front();
                    chk("gnt", 32'(req_gnt_o), 32'(mon_g));
                end
            end
            if (req_rvalid_o != '0) begin
                if (rsp_q.size() == 0) begin
                    chk("rvalid_unexpected", 32'(req_rvalid_o), 32'd0);
                end else begin
                    mon_r = rsp_q.pop_front();
                    chk("rvalid_vec", 32'(req_rvalid_o), 32'(mon_r.vec));
                    chk("rsp_err", 32'(req_err_o), 32'(mon_r.err));
                    chk("rsp_rdata", req_rdata_o, mon_r.rdata);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i = 1'b1;
        idle_ops();
        for (int i = 0; i < N; i++) begin
            req_addr[i]  = 32'h100 * (i + 1);
            req_we[i]    = 1'b0;
            req_wdata[i] = 32'h0;
        end
        counter_gnt_i    = 1'b0;
        counter_rvalid_i = 1'b0;
        counter_err_i    = 1'b0;
        counter_rdata_i  = 32'h0;
        cyc();
        cyc();
        rst_i = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_gnt", 32'(req_gnt_o), 32'd0);
        chk("rst_rvalid", 32'(req_rvalid_o), 32'd0);
        chk("rst_err", 32'(req_err_o), 32'd0);
        chk("rst_op", 32'(counter_op_o), 32'(PMC_IDLE));
        cyc();

        // Single requester read
        req_op[0] = PMC_REQ; req_addr[0] = 32'h10; req_we[0] = 1'b0;
        counter_gnt_i = 1'b1;
        exp_gnt(3'b001);
        @(negedge clk);
        chk("t1_op", 32'(counter_op_o), 32'(PMC_REQ));
        chk("t1_addr", counter_addr_o, 32'h10);
        cyc();
        req_op[0] = PMC_IDLE;
        @(negedge clk);
        chk("t1_req_op", 32'(counter_op_o), 32'(PMC_IDLE));
        chk("t1_latched_addr", counter_addr_o, 32'h10);
        cyc();
        counter_rvalid_i = 1'b1; counter_rdata_i = 32'hDEADBEEF;
        exp_rsp(3'b001, 1'b0, 32'hDEADBEEF);
        cyc();
        counter_rvalid_i = 1'b0;

        // Contention from a fresh pointer: expect 0,1,2,0
        rst_i = 1'b1;
        cyc();
        rst_i = 1'b0;
        req_addr[0] = 32'h100;
        for (int i = 0; i < N; i++) req_op[i] = PMC_REQ;
        for (int i = 0; i < 4; i++) begin
            onehot = '0;
            onehot[i % 3] = 1'b1;
            exp_gnt(onehot);
            @(negedge clk);
            chk("cont_addr", counter_addr_o, 32'h100 * ((i % 3) + 1));
            cyc();
            counter_rvalid_i = 1'b1;
            counter_err_i    = (i == 2);
            counter_rdata_i  = 32'h1000 + i;
            exp_rsp(onehot, (i == 2), 32'h1000 + i);
            if (i == 3) idle_ops();
            cyc();
            counter_rvalid_i = 1'b0;
            counter_err_i    = 1'b0;
        end

        // WFP hold for 20 cycles on requester 1
        req_op[1] = PMC_WFP;
        exp_gnt(3'b010);
        @(negedge clk);
        chk("wfp_grant_op", 32'(counter_op_o), 32'(PMC_WFP));
        cyc();
        req_op[1] = PMC_IDLE;
        for (int j = 0; j < 20; j++) begin
            @(negedge clk);
            chk("wfp_hold", 32'(counter_op_o), 32'(PMC_WFP));
            cyc();
        end
        counter_rvalid_i = 1'b1; counter_rdata_i = 32'hCAFEF00D;
        exp_rsp(3'b010, 1'b0, 32'hCAFEF00D);
        @(negedge clk);
        chk("wfp_rvalid_op", 32'(counter_op_o), 32'(PMC_IDLE));
        cyc();
        counter_rvalid_i = 1'b0;

        // Timeout and drain on requester 2
        req_op[2] = PMC_REQ; req_we[2] = 1'b1; req_wdata[2] = 32'h55AA55AA;
        exp_gnt(3'b100);
        @(negedge clk);
        chk("tmo_we", 32'(counter_we_o), 32'd1);
        chk("tmo_wdata", counter_wdata_o, 32'h55AA55AA);
        cyc();
        req_op[2] = PMC_IDLE;
        counter_rdata_i = 32'hFFFFFFFF;
        repeat (3) cyc();
        exp_rsp(3'b100, 1'b1, 32'h0);
        cyc();
        req_op[0] = PMC_REQ; req_addr[0] = 32'h10;
        for (int j = 0; j < 2; j++) begin
            @(negedge clk);
            chk("drain_op", 32'(counter_op_o), 32'(PMC_IDLE));
            cyc();
        end
        counter_rvalid_i = 1'b1; counter_rdata_i = 32'h77;
        @(negedge clk);
        chk("drain_no_rvalid", 32'(req_rvalid_o), 32'd0);
        cyc();
        counter_rvalid_i = 1'b0;
        exp_gnt(3'b001);
        cyc();
        req_op[0] = PMC_IDLE;
        counter_rvalid_i = 1'b1; counter_rdata_i = 32'h11111111;
        exp_rsp(3'b001, 1'b0, 32'h11111111);
        cyc();
        counter_rvalid_i = 1'b0;

        // rvalid in the same cycle the timeout would fire
        req_op[1] = PMC_REQ;
        exp_gnt(3'b010);
        cyc();
        req_op[1] = PMC_IDLE;
        repeat (3) cyc();
        counter_rvalid_i = 1'b1; counter_err_i = 1'b0; counter_rdata_i = 32'h12345678;
        exp_rsp(3'b010, 1'b0, 32'h12345678);
        req_op[2] = PMC_REQ;
        cyc();
        counter_rvalid_i = 1'b0;
        exp_gnt(3'b100);
        cyc();
        req_op[2] = PMC_IDLE;
        counter_rvalid_i = 1'b1; counter_err_i = 1'b1; counter_rdata_i = 32'hBAD0BAD0;
        exp_rsp(3'b100, 1'b1, 32'hBAD0BAD0);
        cyc();
        counter_rvalid_i = 1'b0; counter_err_i = 1'b0;

        // Spurious rvalid in IDLE
        counter_rvalid_i = 1'b1; counter_rdata_i = 32'h99;
        for (int j = 0; j < 2; j++) begin
            @(negedge clk);
            chk("idle_spurious", 32'(req_rvalid_o), 32'd0);
            cyc();
        end
        counter_rvalid_i = 1'b0;

        // Reset while in WFX
        req_op[0] = PMC_WFO;
        exp_gnt(3'b001);
        cyc();
        req_op[0] = PMC_IDLE;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            chk("wfo_hold", 32'(counter_op_o), 32'(PMC_WFO));
            cyc();
        end
        rst_i = 1'b1;
        cyc();
        rst_i = 1'b0;
        counter_rvalid_i = 1'b1; counter_rdata_i = 32'h5;
        @(negedge clk);
        chk("post_rst_op", 32'(counter_op_o), 32'(PMC_IDLE));
        chk("post_rst_rvalid", 32'(req_rvalid_o), 32'd0);
        cyc();
        counter_rvalid_i = 1'b0;
        req_op[0] = PMC_REQ; req_op[1] = PMC_REQ;
        exp_gnt(3'b001);
        cyc();
        idle_ops();
        counter_rvalid_i = 1'b1; counter_rdata_i = 32'hA5A5A5A5;
        exp_rsp(3'b001, 1'b0, 32'hA5A5A5A5);
        cyc();
        counter_rvalid_i = 1'b0;
        cyc();

        chk("gnt_q_left", 32'(gnt_q.size()), 32'd0);
        chk("rsp_q_left", 32'(rsp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
